// File: rtl/regfile_mp.sv
// Multi-port register file with self-clearing init and optional busy scoreboard.
// Define REGFILE_SCOREBOARD_EN to build the per-entry busy tracking.
module regfile_mp #(
   parameter  int XLEN  = 32,
   parameter  int NREGS = 32,
   parameter  int NRD   = 2,
   parameter  int NWR   = 2,
   localparam int AW    = $clog2(NREGS)
) (
   input  logic                      clk,
   input  logic                      rst,
   output logic                      ready,
   input  logic [NRD-1:0][AW-1:0]    ra,
   output logic [NRD-1:0][XLEN-1:0]  rd,
   input  logic [NWR-1:0]            we,
   input  logic [NWR-1:0][AW-1:0]    wa,
   input  logic [NWR-1:0][XLEN-1:0]  wd,
   input  logic                      iss_valid,
   input  logic [AW-1:0]             iss_rd,
   output logic [NRD-1:0]            rbusy
);

   typedef enum logic {INIT, RUN} state_t;

   state_t          state;
   state_t          state_nx;
   logic [AW-1:0]   cnt;
   logic            run;
   logic [XLEN-1:0] mem [NREGS];

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= INIT;
         cnt   <= '0;
      end else begin
         state <= state_nx;
         if (state == INIT)
            cnt <= cnt + 1'b1;
      end
   end

   always_comb begin
      state_nx = state;
      unique case (state)
         INIT:    if (cnt == AW'(NREGS - 1)) state_nx = RUN;
         RUN:     state_nx = RUN;
         default: state_nx = INIT;
      endcase
   end

   // rst is sampled at the edge, so gate it in to keep outputs quiet before it lands
   always_comb begin
      run   = (state == RUN) && !rst;
      ready = run;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         if (state == INIT) begin
            mem[cnt] <= '0;
         end else begin
            for (int j = 0; j < NWR; j++)
               if (we[j] && wa[j] != '0)
                  mem[wa[j]] <= wd[j];
         end
      end
   end

   // ascending loop leaves the highest matching port in place
   always_comb begin
      for (int i = 0; i < NRD; i++) begin
         rd[i] = '0;
         if (run && ra[i] != '0) begin
            rd[i] = mem[ra[i]];
            for (int j = 0; j < NWR; j++)
               if (we[j] && wa[j] == ra[i])
                  rd[i] = wd[j];
         end
      end
   end

`ifdef REGFILE_SCOREBOARD_EN
   logic [NREGS-1:0] busy;
   logic [NREGS-1:0] busy_nx;
   logic [NRD-1:0]   hit;

   // clear first, set last: a new producer supersedes a retiring one
   always_comb begin
      busy_nx = busy;
      if (run) begin
         for (int j = 0; j < NWR; j++)
            if (we[j] && wa[j] != '0)
               busy_nx[wa[j]] = 1'b0;
         if (iss_valid && iss_rd != '0)
            busy_nx[iss_rd] = 1'b1;
      end
      busy_nx[0] = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (rst)
         busy <= '0;
      else
         busy <= busy_nx;
   end

   always_comb begin
      for (int i = 0; i < NRD; i++) begin
         hit[i] = 1'b0;
         for (int j = 0; j < NWR; j++)
            if (we[j] && wa[j] == ra[i])
               hit[i] = 1'b1;
         rbusy[i] = run && busy[ra[i]] && !hit[i];
      end
   end
`else
   logic unused_iss;

   assign unused_iss = &{1'b0, iss_valid, iss_rd};
   assign rbusy      = '0;
`endif

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: init/reset timing, bypass, conflicts, scoreboard.
// A second instance covers NREGS=16, NRD=4, NWR=1.
module tb_regfile_mp;

`ifdef REGFILE_SCOREBOARD_EN
   localparam logic SB = 1'b1;
`else
   localparam logic SB = 1'b0;
`endif

   logic              clk;
   logic              rst;
   logic              ready;
   logic [1:0][4:0]   ra;
   logic [1:0][31:0]  rd;
   logic [1:0]        we;
   logic [1:0][4:0]   wa;
   logic [1:0][31:0]  wd;
   logic              iss_valid;
   logic [4:0]        iss_rd;
   logic [1:0]        rbusy;

   logic              ready2;
   logic [3:0][3:0]   ra2;
   logic [3:0][31:0]  rd2;
   logic [0:0]        we2;
   logic [0:0][3:0]   wa2;
   logic [0:0][31:0]  wd2;
   logic              iss_valid2;
   logic [3:0]        iss_rd2;
   logic [3:0]        rbusy2;

   logic [31:0] sbq[$];
   int n_cmp = 0;
   int n_bad = 0;

   regfile_mp #(.XLEN(32), .NREGS(32), .NRD(2), .NWR(2)) dut (
      .clk(clk), .rst(rst), .ready(ready),
      .ra(ra), .rd(rd), .we(we), .wa(wa), .wd(wd),
      .iss_valid(iss_valid), .iss_rd(iss_rd), .rbusy(rbusy)
   );

   regfile_mp #(.XLEN(32), .NREGS(16), .NRD(4), .NWR(1)) dut2 (
      .clk(clk), .rst(rst), .ready(ready2),
      .ra(ra2), .rd(rd2), .we(we2), .wa(wa2), .wd(wd2),
      .iss_valid(iss_valid2), .iss_rd(iss_rd2), .rbusy(rbusy2)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL timeout: bench did not finish");
      $fatal(1, "timeout");
   end

   task automatic ex(input logic [31:0] v);
      sbq.push_back(v);
   endtask

   task automatic chk(input string tag, input logic [31:0] obs);
      logic [31:0] e;
      n_cmp++;
      if (sbq.size() == 0) begin
         n_bad++;
         $error("FAIL %s: observed %h, no expected value queued", tag, obs);
         return;
      end
      e = sbq.pop_front();
      assert (obs === e) else begin
         n_bad++;
         $error("FAIL %s: observed %h expected %h", tag, obs, e);
      end
   endtask

   initial begin
      rst = 1'b1;
      ra = '0; we = '0; wa = '0; wd = '0;
      iss_valid = 1'b0; iss_rd = '0;
      ra2 = '0; we2 = '0; wa2 = '0; wd2 = '0;
      iss_valid2 = 1'b0; iss_rd2 = '0;

      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      ra[0] = 5'd5;
      ra[1] = 5'd31;
      #1;
      ex(0); chk("ready_after_rst", {31'b0, ready});

      // abort init once cnt has reached 10
      for (int k = 1; k <= 10; k++) @(negedge clk);
      rst = 1'b1;
      #1;
      ex(0); chk("ready_rst_mid_init", {31'b0, ready});
      @(negedge clk);
      rst = 1'b0;

      for (int k = 1; k <= 32; k++) begin
         @(negedge clk);
         #1;
         ex({31'b0, k == 32}); chk("ready_init_count", {31'b0, ready});
         ex({31'b0, k >= 16}); chk("ready2_init_count", {31'b0, ready2});
         if (k < 32) begin
            ex(0); chk("rd0_during_init", rd[0]);
            ex(0); chk("rd1_during_init", rd[1]);
         end
      end
      ex(0); chk("rd1_x31_zeroed", rd[1]);

      @(negedge clk);
      we = 2'b01; wa[0] = 5'd5; wd[0] = 32'hDEADBEEF;
      ra[0] = 5'd5; ra[1] = 5'd6;
      #1;
      ex(32'hDEADBEEF); chk("bypass_x5", rd[0]);
      ex(0); chk("x6_zero", rd[1]);

      @(negedge clk);
      we = '0;
      #1;
      ex(32'hDEADBEEF); chk("hold_x5", rd[0]);

      @(negedge clk);
      we = 2'b11; wa[0] = 5'd7; wa[1] = 5'd7;
      wd[0] = 32'h11; wd[1] = 32'h22;
      ra[1] = 5'd7;
      #1;
      ex(32'h22); chk("bypass_conflict_x7", rd[1]);

      @(negedge clk);
      we = 2'b10; wa[1] = 5'd0; wd[1] = 32'hFFFFFFFF;
      ra[0] = 5'd0;
      #1;
      ex(32'h22); chk("commit_conflict_x7", rd[1]);
      ex(0); chk("x0_write_bypass", rd[0]);

      @(negedge clk);
      we = '0;
      #1;
      ex(0); chk("x0_after_write", rd[0]);
      ex(32'h22); chk("x7_hold", rd[1]);

      // scoreboard
      @(negedge clk);
      iss_valid = 1'b1; iss_rd = 5'd9; ra[0] = 5'd9;
      #1;
      ex(0); chk("rbusy_issue_cycle", {31'b0, rbusy[0]});

      @(negedge clk);
      iss_valid = 1'b0;
      #1;
      ex({31'b0, SB}); chk("rbusy_after_issue", {31'b0, rbusy[0]});

      @(negedge clk);
      we = 2'b10; wa[1] = 5'd9; wd[1] = 32'h99;
      #1;
      ex(0); chk("rbusy_wb_same_cycle", {31'b0, rbusy[0]});
      ex(32'h99); chk("rd_wb_bypass_x9", rd[0]);

      @(negedge clk);
      we = '0;
      #1;
      ex(0); chk("rbusy_after_wb", {31'b0, rbusy[0]});

      @(negedge clk);
      iss_valid = 1'b1; iss_rd = 5'd9;
      we = 2'b01; wa[0] = 5'd9; wd[0] = 32'hA9;
      #1;
      ex(0); chk("rbusy_set_clr_cycle", {31'b0, rbusy[0]});

      @(negedge clk);
      iss_valid = 1'b0; we = '0;
      #1;
      ex({31'b0, SB}); chk("rbusy_set_wins", {31'b0, rbusy[0]});
      ex(32'hA9); chk("x9_value", rd[0]);

      // second instance: four simultaneous reads
      for (int r = 1; r <= 4; r++) begin
         @(negedge clk);
         we2 = 1'b1; wa2[0] = 4'(r); wd2[0] = 32'h1111_0000 + 32'(r);
      end
      @(negedge clk);
      we2 = 1'b0;
      for (int i = 0; i < 4; i++) ra2[i] = 4'(i + 1);
      #1;
      for (int i = 0; i < 4; i++) begin
         ex(32'h1111_0000 + 32'(i + 1)); chk("dut2_read", rd2[i]);
      end
      ex(0); chk("dut2_rbusy", {28'b0, rbusy2});

      // mid-RUN reset with x9 still busy
      @(negedge clk);
      rst = 1'b1; ra[0] = 5'd5; ra[1] = 5'd9;
      #1;
      ex(0); chk("ready_rst_mid_run", {31'b0, ready});
      ex(0); chk("rd_during_rst", rd[0]);
      ex(0); chk("rbusy_during_rst", {31'b0, rbusy[1]});

      @(negedge clk);
      rst = 1'b0;
      for (int k = 1; k <= 32; k++) @(negedge clk);
      #1;
      ex(1); chk("ready_reinit", {31'b0, ready});
      ex(0); chk("x5_cleared", rd[0]);
      ex(0); chk("busy_cleared_x9", {31'b0, rbusy[1]});

      if (sbq.size() != 0) begin
         n_cmp++;
         n_bad++;
         $display("FAIL leftover: %0d expected values unused, required 0", sbq.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
